// File: rtl/display_pkg.sv
// Shared types, segment decode table and width helper for the display scan driver.
package display_pkg;

   typedef logic [6:0] seg_t;

   // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
   localparam seg_t SEG_LUT [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output seg_t       seg_o
);

   always_comb begin
      seg_o = SEG_LUT[nibble_i];
   end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver: shadow-latched nibbles, prescaled
// digit scan, per-digit blanking/decimal point and an anode dead-time at slot start.
module display_scan_mux
   import display_pkg::*;
#(
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV = 27000,
   parameter int unsigned DEAD_CYC    = 2,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [4*N_DIGITS-1:0] data_i,
   input  logic [N_DIGITS-1:0]   blank_i,
   input  logic [N_DIGITS-1:0]   dp_i,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [N_DIGITS-1:0]   an_o,
   output logic                  frame_o
);

   localparam int unsigned IDX_W = clog2_min1(N_DIGITS);
   localparam int unsigned PRE_W = clog2_min1(REFRESH_DIV);

   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
   localparam logic [PRE_W-1:0]    LAST_PRE = PRE_W'(REFRESH_DIV - 1);
   localparam logic [PRE_W-1:0]    DEAD_END = PRE_W'(DEAD_CYC);
   localparam seg_t                SEG_POL  = {7{ACTIVE_LOW}};
   localparam logic [N_DIGITS-1:0] AN_POL   = {N_DIGITS{ACTIVE_LOW}};

   logic [PRE_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*N_DIGITS-1:0] data_sh_q, data_sh_d;
   logic [N_DIGITS-1:0]   blank_sh_q, blank_sh_d;
   logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
   seg_t                  seg_out_q, seg_out_d;
   logic                  dp_out_q, dp_out_d;
   logic [N_DIGITS-1:0]   an_out_q, an_out_d;
   logic                  frame_q, frame_d;

   logic [3:0]            cur_nib;
   logic                  cur_blank;
   logic                  cur_dp;
   logic [N_DIGITS-1:0]   an_act;
   seg_t                  cur_seg;

   // Prescaler, digit index and shadow registers.
   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      frame_d = 1'b0;
      if (presc_q == LAST_PRE) begin
         presc_d = '0;
         frame_d = (idx_q == LAST_IDX);
         idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end

      data_sh_d  = load_i ? data_i  : data_sh_q;
      blank_sh_d = load_i ? blank_i : blank_sh_q;
      dp_sh_d    = load_i ? dp_i    : dp_sh_q;
   end

   // Constant-index compare avoids a variable part-select on the shadow word.
   always_comb begin
      cur_nib   = '0;
      cur_blank = 1'b1;
      cur_dp    = 1'b0;
      an_act    = '0;
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_nib   = data_sh_q[4*k +: 4];
            cur_blank = blank_sh_q[k];
            cur_dp    = dp_sh_q[k];
            an_act[k] = 1'b1;
         end
      end
      if (presc_q < DEAD_END) begin
         an_act = '0;
      end
   end

   hex_to_7seg u_dec (
      .nibble_i (cur_nib),
      .seg_o    (cur_seg)
   );

   // Segments pre-charge during the dead time; only the anodes are held off.
   always_comb begin
      seg_out_d = (cur_blank ? 7'b0000000 : cur_seg) ^ SEG_POL;
      dp_out_d  = (cur_dp & ~cur_blank) ^ ACTIVE_LOW;
      an_out_d  = an_act ^ AN_POL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q    <= '0;
         idx_q      <= '0;
         data_sh_q  <= '0;
         blank_sh_q <= '1;
         dp_sh_q    <= '0;
         seg_out_q  <= SEG_POL;
         dp_out_q   <= ACTIVE_LOW;
         an_out_q   <= AN_POL;
         frame_q    <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         data_sh_q  <= data_sh_d;
         blank_sh_q <= blank_sh_d;
         dp_sh_q    <= dp_sh_d;
         seg_out_q  <= seg_out_d;
         dp_out_q   <= dp_out_d;
         an_out_q   <= an_out_d;
         frame_q    <= frame_d;
      end
   end

   assign seg_o   = seg_out_q;
   assign dp_o    = dp_out_q;
   assign an_o    = an_out_q;
   assign frame_o = frame_q;

endmodule
